// File: rtl/adsr_pkg.sv
// ============================================================================
// adsr_pkg : shared envelope state and waveform-select encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_PULSE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/adsr_envelope.sv
// ============================================================================
// adsr_envelope : prescaled, rate-based, retriggerable ADSR envelope
// Rev 1.0
// ============================================================================
`default_nettype none

module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ENV_W  = 16,
    parameter int PRESC  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              gate_i,
    input  logic [ENV_W-1:0]  attack_rate_i,
    input  logic [ENV_W-1:0]  decay_rate_i,
    input  logic [DATA_W-1:0] sustain_level_i,
    input  logic [ENV_W-1:0]  release_rate_i,
    output logic [DATA_W-1:0] env_out_o,
    output logic              active_o,
    output logic              gate_rise_o
);

    localparam int               CNT_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESC - 1);
    localparam logic [ENV_W-1:0] ENV_MAX  = '1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gate_q;
    adsr_state_e        state_q, state_d;
    logic [ENV_W-1:0]   env_q, env_d;

    logic               tick, rise, fall;
    logic [ENV_W-1:0]   target;
    logic [ENV_W:0]     att_sum;
    logic signed [ENV_W+1:0] dec_diff;

    assign tick   = (cnt_q == CNT_LAST);
    assign cnt_d  = tick ? '0 : cnt_q + 1'b1;
    assign rise   = gate_i & ~gate_q;
    assign fall   = ~gate_i & gate_q;
    assign target = ENV_W'(sustain_level_i) << (ENV_W - DATA_W);

    // Extra headroom bits so overshoot and undershoot are detected, not wrapped.
    assign att_sum  = {1'b0, env_q} + {1'b0, attack_rate_i};
    assign dec_diff = $signed({2'b00, env_q}) - $signed({2'b00, decay_rate_i});

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            ST_IDLE: env_d = '0;
            ST_ATTACK: if (tick) begin
                if (attack_rate_i == '0 || att_sum >= {1'b0, ENV_MAX}) begin
                    env_d   = ENV_MAX;
                    state_d = ST_DECAY;
                end else begin
                    env_d = att_sum[ENV_W-1:0];
                end
            end
            ST_DECAY: if (tick) begin
                if (decay_rate_i == '0 || dec_diff <= $signed({2'b00, target})) begin
                    env_d   = target;
                    state_d = ST_SUSTAIN;
                end else begin
                    env_d = dec_diff[ENV_W-1:0];
                end
            end
            ST_SUSTAIN: env_d = target;
            ST_RELEASE: if (tick) begin
                if (release_rate_i == '0 || env_q <= release_rate_i) begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    env_d = env_q - release_rate_i;
                end
            end
            default: begin
                env_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Gate edges win over tick updates; env holds so retrigger is click-free.
        if (rise) begin
            state_d = ST_ATTACK;
            env_d   = env_q;
        end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
            env_d   = env_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            state_q <= ST_IDLE;
            env_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            gate_q  <= gate_i;
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    assign env_out_o   = env_q[ENV_W-1 -: DATA_W];
    assign active_o    = (state_q != ST_IDLE);
    assign gate_rise_o = rise;

endmodule

`default_nettype wire

// File: rtl/adsr_multiwave_generator.sv
// ============================================================================
// adsr_multiwave_generator : phase-accumulator oscillator with four waveforms
// scaled by an ADSR envelope through a fixed 2-clk multiply pipeline.  Rev 1.0
// ============================================================================
`default_nettype none

module adsr_multiwave_generator
    import adsr_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 24,
    parameter int ENV_W   = 16,
    parameter int PRESC   = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic [1:0]         wave_sel,
    input  logic [DATA_W-1:0]  duty,
    input  logic               phase_sync,
    input  logic               gate,
    input  logic [ENV_W-1:0]   attack_rate,
    input  logic [ENV_W-1:0]   decay_rate,
    input  logic [DATA_W-1:0]  sustain_level,
    input  logic [ENV_W-1:0]   release_rate,
    output logic [DATA_W-1:0]  wave_out,
    output logic [DATA_W-1:0]  env_out,
    output logic               active
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DATA_W-1:0]  raw_q, wave_q;
    logic [DATA_W:0]    s_q;
    logic [DATA_W-1:0]  saw, tri_t, raw;
    logic [2*DATA_W:0]  prod;
    logic               gate_rise;
    logic               unused_prod;

    adsr_envelope #(
        .DATA_W (DATA_W),
        .ENV_W  (ENV_W),
        .PRESC  (PRESC)
    ) u_env (
        .clk             (clk),
        .reset_n         (reset_n),
        .gate_i          (gate),
        .attack_rate_i   (attack_rate),
        .decay_rate_i    (decay_rate),
        .sustain_level_i (sustain_level),
        .release_rate_i  (release_rate),
        .env_out_o       (env_out),
        .active_o        (active),
        .gate_rise_o     (gate_rise)
    );

    assign phase_d = (phase_sync && gate_rise) ? '0 : phase_q + tune_word;

    assign saw   = phase_q[PHASE_W-1 -: DATA_W];
    assign tri_t = phase_q[PHASE_W-2 -: DATA_W];

    always_comb begin
        raw = saw;
        case (wave_sel)
            WAVE_SAW:    raw = saw;
            WAVE_SQUARE: raw = phase_q[PHASE_W-1] ? '0 : '1;
            WAVE_TRI:    raw = phase_q[PHASE_W-1] ? ~tri_t : tri_t;
            WAVE_PULSE:  raw = (saw < duty) ? '1 : '0;
            default:     raw = saw;
        endcase
    end

    // Scaling by env+1 makes full envelope a pass-through and zero envelope silent.
    assign prod        = raw_q * s_q;
    assign unused_prod = ^{prod[2*DATA_W], prod[DATA_W-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            raw_q   <= '0;
            s_q     <= '0;
            wave_q  <= '0;
        end else begin
            phase_q <= phase_d;
            raw_q   <= raw;
            s_q     <= {1'b0, env_out} + 1'b1;
            wave_q  <= prod[2*DATA_W-1:DATA_W];
        end
    end

    assign wave_out = wave_q;

endmodule

`default_nettype wire
